pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] are 0.
REQ-002 Parameter CNT_W, default 16: width of the redirect counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 stall  input  1  fetch/decode stall; PC is held while high.
REQ-006 branch_taken  input  1  branch/jump resolved taken this cycle (from the branch comparator).
REQ-007 branch_target  input  32  target address accompanying branch_taken.
REQ-008 pc_out  output  32  current fetch PC (registered).
REQ-009 flush  output  1  kill the younger in-flight instruction; combinational, high only in the redirect-fire cycle.
REQ-010 redirect_pending  output  1  high while a taken branch is held behind a stall (state HOLD).
REQ-011 redirect_count  output  CNT_W  number of redirects fired since reset, saturating.

Function
REQ-012 FSM states: RUN and HOLD; reset state RUN.
REQ-013 RUN, stall=0, branch_taken=0: pc_out <= pc_out + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); flush=0.
REQ-014 RUN, stall=0, branch_taken=1: redirect fires; pc_out <= {branch_target[31:2],2'b00}; flush=1 that cycle; stays RUN.
REQ-015 RUN, stall=1, branch_taken=0: pc_out holds; flush=0.
REQ-016 RUN, stall=1, branch_taken=1: target latched (low 2 bits cleared); pc_out holds; flush=0; next state HOLD.
REQ-017 HOLD, stall=1: pc_out and latched target hold; redirect_pending=1; flush=0.
REQ-018 HOLD, stall=0: redirect fires with latched target; pc_out <= latched target; flush=1; next state RUN.
REQ-019 branch_taken while in HOLD is ignored (older branch wins); branch_target not sampled.
REQ-020 Redirect-fire = (RUN & !stall & branch_taken) | (HOLD & !stall); flush equals redirect-fire exactly.
REQ-021 redirect_count increments by 1 on each redirect-fire; saturates at 2^CNT_W-1, no wrap.
REQ-022 Redirect latency: pc_out shows target on the clock edge ending the fire cycle (1 cycle).
REQ-023 Misaligned targets (bits [1:0]!=0) are silently word-aligned; no trap generated.

Reset
REQ-024 rst=1 asynchronously forces: pc_out=RESET_PC, state=RUN, latched target=0, redirect_count=0, redirect_pending=0.
REQ-025 flush=0 while rst=1, regardless of other inputs.
REQ-026 Reset mid-HOLD discards the pending redirect; first post-reset fetch PC is RESET_PC.

Structure
REQ-027 State enum (RUN, HOLD) and RESET_PC default constant live in shared package pipeline_pkg.
REQ-028 Saturating counter is one sub-module sat_counter (parameter W; inputs clk, rst, inc; output count).
REQ-029 No combinational path from branch_target to pc_out; pc_out comes directly from a register.

Verification
REQ-030 Reset release, no stall, no branch, 4 cycles -> pc_out 0,4,8,12,16; flush=0 throughout.
REQ-031 pc_out=0x100, branch_taken=1, target=0x2003, stall=0 -> flush=1 same cycle; next pc_out=0x2000; redirect_count=1.
REQ-032 pc_out=0x40, stall=1 with branch_taken=1 target=0x800, stall held 3 cycles, second branch target=0x900 during hold -> pc_out stays 0x40, redirect_pending=1, flush=0; stall drops -> flush=1, next pc_out=0x800.
REQ-033 RESET_PC=32'hFFFF_FFF8, no stall -> pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 CNT_W=4, 17 back-to-back taken branches -> redirect_count reaches 15 and stays 15.
REQ-035 Assert rst asynchronously (between edges) while in HOLD -> pc_out=RESET_PC, redirect_pending=0 immediately; no flush after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: redirect FSM states and the default reset PC.
package pipeline_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: advances by 4, redirects on taken branches, and parks a
// branch that arrives during a stall until the stall clears.
module pc_redirect_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc_out,
  output logic             flush,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_count
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] target_reg, target_next;
  logic [31:0] aligned_target;
  logic        fire;

  assign aligned_target = branch_target & ~32'h0000_0003;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
    end
  end

  // In HOLD the parked (older) branch owns the redirect; new branches are ignored.
  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    pc_next     = pc_reg;
    fire        = 1'b0;
    if (state_reg == HOLD) begin
      if (!stall) begin
        fire       = 1'b1;
        pc_next    = target_reg;
        state_next = RUN;
      end
    end else begin
      if (branch_taken && stall) begin
        target_next = aligned_target;
        state_next  = HOLD;
      end else if (branch_taken) begin
        fire    = 1'b1;
        pc_next = aligned_target;
      end else if (!stall) begin
        pc_next = pc_reg + 32'd4;
      end
    end
  end

  assign pc_out           = pc_reg;
  assign flush            = fire & ~rst;
  assign redirect_pending = (state_reg == HOLD);

  sat_counter #(
    .W(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (fire),
    .count(redirect_count)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic        flush, redirect_pending;
  logic [15:0] redirect_count;

  logic        rst2, stall2, branch_taken2;
  logic [31:0] branch_target2;
  logic [31:0] pc_out2;
  logic        flush2, redirect_pending2;
  logic [3:0]  redirect_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .flush(flush),
    .redirect_pending(redirect_pending), .redirect_count(redirect_count)
  );

  pc_redirect_ctrl #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .branch_taken(branch_taken2),
    .branch_target(branch_target2), .pc_out(pc_out2), .flush(flush2),
    .redirect_pending(redirect_pending2), .redirect_count(redirect_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        exp_flush;
    logic        exp_pend;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vec [16];

  // Reference model state
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] m_hold_q[$];
  logic        m_fire;
  logic [31:0] r;

  initial begin
    vec[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h4};
    vec[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8};
    vec[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hC};
    vec[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h10};
    vec[4]  = '{1'b0, 1'b1, 32'h2003,      1'b1, 1'b0, 32'h2000};
    vec[5]  = '{1'b1, 1'b1, 32'h42,        1'b0, 1'b0, 32'h2000};
    vec[6]  = '{1'b1, 1'b1, 32'h900,       1'b0, 1'b1, 32'h2000};
    vec[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2000};
    vec[8]  = '{1'b0, 1'b1, 32'h1234,      1'b1, 1'b1, 32'h40};
    vec[9]  = '{1'b1, 1'b1, 32'h800,       1'b0, 1'b0, 32'h40};
    vec[10] = '{1'b1, 1'b1, 32'h900,       1'b0, 1'b1, 32'h40};
    vec[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h40};
    vec[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h800};
    vec[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h804};
    vec[14] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFC};
    vec[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0};

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h1234;
    rst2 = 1'b1; stall2 = 1'b0; branch_taken2 = 1'b0; branch_target2 = 32'h0;

    // Reset state, with a would-be redirect on the inputs
    @(negedge clk);
    #1;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_flush", flush, 1'b0);
    chk("reset_pending", redirect_pending, 1'b0);
    chk("reset_count", redirect_count, 16'd0);
    branch_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Table: each row starts on a falling edge
    for (int i = 0; i < 16; i++) begin
      stall = vec[i].st; branch_taken = vec[i].br; branch_target = vec[i].tgt;
      #1;
      chk($sformatf("vec%0d_flush", i), flush, vec[i].exp_flush);
      chk($sformatf("vec%0d_pending", i), redirect_pending, vec[i].exp_pend);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pc", i), pc_out, vec[i].exp_pc);
      $display("vec %0d stall=%b br=%b tgt=%h -> pc=%h", i, vec[i].st, vec[i].br, vec[i].tgt, pc_out);
      @(negedge clk);
    end
    chk("table_count", redirect_count, 16'd4);

    // Asynchronous reset while a redirect is parked
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h700;
    @(posedge clk);
    #1;
    chk("pre_hold_pc", pc_out, 32'h700);
    @(negedge clk);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
    @(posedge clk);
    #1;
    chk("hold_pending", redirect_pending, 1'b1);
    #2;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    #1;
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_pending", redirect_pending, 1'b0);
    chk("async_rst_flush", flush, 1'b0);
    chk("async_rst_count", redirect_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_flush", flush, 1'b0);
    chk("post_rst_pc", pc_out, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_pc_next", pc_out, 32'h4);
    chk("post_rst_count", redirect_count, 16'd0);

    // Randomized traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_cnt = 0; m_hold_q.delete();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) < 2);
      branch_taken = $urandom_range(0, 1);
      r = $urandom;
      branch_target = r;
      m_fire = !stall && ((m_hold_q.size() != 0) || branch_taken);
      #1;
      chk("rnd_flush", flush, m_fire);
      chk("rnd_pending", redirect_pending, m_hold_q.size() != 0);
      if (m_hold_q.size() != 0) begin
        if (!stall) m_pc = m_hold_q.pop_front();
      end else if (branch_taken && stall) begin
        m_hold_q.push_back({r[31:2], 2'b00});
      end else if (branch_taken) begin
        m_pc = {r[31:2], 2'b00};
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
      if (m_fire && m_cnt < 65535) m_cnt++;
      @(posedge clk);
      #1;
      chk("rnd_pc", pc_out, m_pc);
      chk("rnd_count", redirect_count, m_cnt[15:0]);
      @(negedge clk);
    end

    // Second instance: high reset PC wraps, 4-bit counter saturates
    #1;
    chk("hi_reset_pc", pc_out2, 32'hFFFF_FFF8);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("hi_pc0", pc_out2, 32'hFFFF_FFF8);
    chk("hi_flush0", flush2, 1'b0);
    @(posedge clk);
    #1;
    chk("hi_pc1", pc_out2, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("hi_pc2_wrap", pc_out2, 32'h0);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      branch_taken2 = 1'b1;
      r = $urandom;
      branch_target2 = r;
      #1;
      chk($sformatf("sat_flush%0d", i), flush2, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("sat_pc%0d", i), pc_out2, {r[31:2], 2'b00});
      chk($sformatf("sat_count%0d", i), redirect_count2, (i > 15) ? 32'd15 : i);
      $display("branch %0d tgt=%h -> pc=%h count=%0d", i, r, pc_out2, redirect_count2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
